// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and legal parameter bounds for the CPU memory-port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int MEM_LAT_MIN    = 1;
    localparam int MEM_LAT_MAX    = 4;
    localparam int STARVE_MAX_MIN = 1;
    localparam int STARVE_MAX_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data-stage and memory-side signals of the shared port.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [15:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [15:0] dm_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        pipe_stall;

    // The master side is the pipeline plus the memory block around the arbiter.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
    );

endinterface

// File: rtl/mem_port_arbiter_rd_tracker.sv
// Delay line that follows an issued read for MEM_LAT cycles and flags the
// cycle in which MEM_RDATA must be captured, together with the read's owner.
module mem_rd_tracker #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_owner,
    output logic cap_strobe,
    output logic cap_owner
);
    import mem_arb_pkg::*;

    logic [MEM_LAT-1:0] vld;
    logic [MEM_LAT-1:0] own;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            own <= {MEM_LAT{OWN_IF}};
        end else begin
            vld[0] <= push;
            own[0] <= push_owner;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld[i] <= vld[i-1];
                own[i] <= own[i-1];
            end
        end
    end

    assign cap_strobe = vld[MEM_LAT-1];
    assign cap_owner  = own[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single 16-bit memory port between instruction fetch and the data
// stage: arbitrates, sequences each access, and routes read data back.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    logic [1:0]  state;
    logic        owner;
    logic        acc_we;
    logic [3:0]  starve_cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] if_rdata_q;
    logic [15:0] dm_rdata_q;
    logic        if_valid_q;
    logic        dm_valid_q;

    logic any_req;
    logic dm_wins;
    logic in_grant;
    logic rd_push;
    logic cap_strobe;
    logic cap_owner;
    logic dm_rd_busy;

    // DM takes contested arbitrations until IF has lost STARVE_MAX in a row.
    always_comb begin
        any_req    = bus.if_req | bus.dm_req;
        dm_wins    = bus.dm_req & (~bus.if_req | (starve_cnt != 4'(STARVE_MAX)));
        in_grant   = (state == ST_GRANT);
        rd_push    = in_grant & ~acc_we;
        dm_rd_busy = (rd_push | (state == ST_WAIT)) & (owner == OWN_DM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            acc_we     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state <= ST_GRANT;
                        if (dm_wins) begin
                            owner   <= OWN_DM;
                            acc_we  <= bus.dm_we;
                            addr_q  <= bus.dm_addr;
                            wdata_q <= bus.dm_wdata;
                            if (bus.if_req && (starve_cnt < 4'(STARVE_MAX)))
                                starve_cnt <= starve_cnt + 4'd1;
                        end else begin
                            owner      <= OWN_IF;
                            acc_we     <= 1'b0;
                            addr_q     <= bus.if_addr;
                            wdata_q    <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                ST_GRANT: state <= acc_we ? ST_IDLE : ST_WAIT;
                ST_WAIT: begin
                    if (cap_strobe)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_rd_tracker #(
        .MEM_LAT(MEM_LAT)
    ) u_rd_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rd_push),
        .push_owner (owner),
        .cap_strobe (cap_strobe),
        .cap_owner  (cap_owner)
    );

    // Reset clears the tracker too, so a read cut off mid-WAIT never returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_valid_q <= cap_strobe & (cap_owner == OWN_IF);
            dm_valid_q <= cap_strobe & (cap_owner == OWN_DM);
            if (cap_strobe) begin
                if (cap_owner == OWN_DM)
                    dm_rdata_q <= bus.mem_rdata;
                else
                    if_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt     = in_grant & (owner == OWN_IF);
    assign bus.dm_gnt     = in_grant & (owner == OWN_DM);
    assign bus.if_valid   = if_valid_q;
    assign bus.dm_valid   = dm_valid_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.dm_rdata   = dm_rdata_q;
    assign bus.mem_en     = in_grant;
    assign bus.mem_we     = in_grant & acc_we;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.pipe_stall = (bus.dm_req & ~bus.dm_gnt) | dm_rd_busy;

endmodule
